// File: rtl/rv_mem_pkg.sv
// Shared types and widths for the data-memory responder.
package rv_mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmemState_t;

endpackage

// File: rtl/dmem_array.sv
// Byte-lane-writable word array: synchronous write, combinational read.
module dmem_array
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [STRB_W-1:0]              wstrb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] index,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's load/store port.
// Optional access checking (misaligned / out of range) under DMEM_ERR_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting wait states before the access
// RESP  | response held until the core takes it
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmemState_t        state, stateNext;
    logic [CNT_W-1:0]  waitCnt;
    logic [ADDR_W-1:0] latAddr;
    logic              latWe;
    logic [WORD_W-1:0] latWdata;
    logic [STRB_W-1:0] latWstrb;

    logic              loadReq;
    logic              doAccess;
    logic              useLatched;
    logic [ADDR_W-1:0] accAddr;
    logic              accWe;
    logic [WORD_W-1:0] accWdata;
    logic [STRB_W-1:0] accWstrb;
    logic              accFlagged;
    logic [WORD_W-1:0] arrRdata;

    // With zero wait states the access uses the request inputs directly at the accept edge.
    assign accAddr  = useLatched ? latAddr  : req_addr;
    assign accWe    = useLatched ? latWe    : req_we;
    assign accWdata = useLatched ? latWdata : req_wdata;
    assign accWstrb = useLatched ? latWstrb : req_wstrb;

`ifdef DMEM_ERR_CHECK_EN
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);
    assign accFlagged = (accAddr[1:0] != 2'b00) || ({1'b0, accAddr} >= ADDR_LIMIT);
`else
    // Low bits and upper bits are ignored: addresses wrap modulo the array size.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{accAddr[ADDR_W-1:IDX_W+2], accAddr[1:0]};
    assign accFlagged = 1'b0;
`endif

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (doAccess && accWe && !accFlagged),
        .wstrb(accWstrb),
        .index(accAddr[IDX_W+1:2]),
        .wdata(accWdata),
        .rdata(arrRdata)
    );

    // Next-state and handshake decode.
    always_comb begin
        stateNext  = state;
        req_ready  = 1'b0;
        loadReq    = 1'b0;
        doAccess   = 1'b0;
        useLatched = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    loadReq = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        doAccess   = 1'b1;
                        useLatched = 1'b0;
                        stateNext  = RESP;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == CNT_W'(1)) begin
                    doAccess  = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (resp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);

    // State, request latch, wait counter and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            waitCnt    <= '0;
            latAddr    <= '0;
            latWe      <= 1'b0;
            latWdata   <= '0;
            latWstrb   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= stateNext;
            if (loadReq) begin
                latAddr  <= req_addr;
                latWe    <= req_we;
                latWdata <= req_wdata;
                latWstrb <= req_wstrb;
                waitCnt  <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end
            if (doAccess) begin
                resp_rdata <= (accWe || accFlagged) ? '0 : arrRdata;
                resp_err   <= accFlagged;
            end else if (state == RESP && resp_ready) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder with a word-level reference memory.
module tb_dmem_responder;

    localparam int AW = 32;
    localparam int DW = 1024;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];

    dmem_responder #(
        .ADDR_W(AW),
        .DEPTH_WORDS(DW),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_we(req_we),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit isErr(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a % 4 != 0) || (a >= 32'(4 * DW));
`else
        return 1'b0;
`endif
    endfunction

    // One complete transaction; expectations come from the reference memory.
    task automatic doReq(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int hold);
        int n;
        int idx;
        bit err;
        logic [31:0] expRd;
        err   = isErr(addr);
        idx   = int'((addr / 4) % DW);
        expRd = 32'h0;
        if (!we && !err) expRd = model.exists(idx) ? model[idx] : 32'h0;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wdata;
        req_wstrb = wstrb;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (resp_valid === 1'b1) break;
            chk("req_ready_wait", {31'b0, req_ready}, 32'd0);
            n++;
            if (n > 40) begin
                chk("resp_timeout", 32'd0, 32'd1);
                return;
            end
        end
        chk("latency", n, WC);
        chk("rdata", resp_rdata, expRd);
        chk("err", {31'b0, resp_err}, {31'b0, err});
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = $urandom_range(0, 63) * 4;
            @(negedge clk);
            chk("hold_valid", {31'b0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, expRd);
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        @(negedge clk);
        chk("post_valid", {31'b0, resp_valid}, 32'd0);
        chk("post_rdata", resp_rdata, 32'd0);
        chk("post_err", {31'b0, resp_err}, 32'd0);
        chk("post_ready", {31'b0, req_ready}, 32'd1);
        if (we && !err) begin
            logic [31:0] w;
            w = model.exists(idx) ? model[idx] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
            model[idx] = w;
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prior;
        logic [31:0] a;
        // Reset held with a request pending: nothing accepted.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h12345678;
        req_wstrb = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 16; i++) doReq(i * 4, 1'b1, $urandom, 4'hF, 0);

        doReq(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0);
        doReq(32'h10, 1'b0, 32'h0, 4'h0, 0);
        chk("direct_store_load", model[4], 32'hDEADBEEF);
        doReq(32'h10, 1'b1, 32'h11223344, 4'h5, 0);
        doReq(32'h10, 1'b0, 32'h0, 4'h0, 5);
        chk("direct_strobe", model[4], 32'hDE22BE44);
        doReq(32'h14, 1'b1, 32'hFFFFFFFF, 4'h0, 1);
        doReq(32'h14, 1'b0, 32'h0, 4'h0, 0);

        // Reset during WAIT abandons the pending store.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = ~model[8];
        req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_in_wait", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        prior = model[8];
        doReq(32'h20, 1'b0, 32'h0, 4'h0, 0);
        chk("midrst_model", model[8], prior);

        // Boundary addresses: misaligned and one past the end.
        doReq(32'h13, 1'b0, 32'h0, 4'h0, 0);
        doReq(32'(4 * DW), 1'b1, $urandom, 4'hF, 0);
        doReq(32'h0, 1'b0, 32'h0, 4'h0, 0);
        doReq(32'(4 * DW), 1'b0, 32'h0, 4'h0, 0);

        for (int i = 0; i < 150; i++) begin
            a = $urandom_range(0, 15) * 4;
            case ($urandom_range(0, 3))
                0: a = a + $urandom_range(1, 3);
                1: a = a + 32'(4 * DW) * $urandom_range(1, 3);
                default: ;
            endcase
            doReq(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RISC-V core; it is the target end of the core's load/store port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a fixed number of wait states, performs the word access on an internal byte-writable array, then returns a response over a second valid/ready handshake.
- Gives the pipeline's hazard/stall logic a realistic multi-cycle memory to stall against.

Parameters:
- ADDR_W, 32: byte-address width.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 2: wait states between request acceptance and memory access; range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data.
- req_wstrb  in  4  store byte-lane enables; bit i enables byte i.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load data; 0 for stores.
- resp_err  out  1  access error (see Optional Feature).

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter 0. Array contents are not reset.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=0, resp_valid=1.
- Accept: at a clock edge with state IDLE and req_valid=1, latch addr, we, wdata and wstrb.
  - If WAIT_CYCLES=0: perform the access at that same edge and go to RESP.
  - Otherwise: load the counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - The counter decrements each edge.
  - At the edge where the counter equals 1, perform the access and go to RESP.
  - Result: an accept at edge k gives resp_valid=1 from edge k+WAIT_CYCLES.
- Access:
  - Word index is addr[log2(DEPTH_WORDS)+1:2].
  - Load: resp_rdata gets the array word.
  - Store: write only the enabled byte lanes; resp_rdata gets 0.
  - Store with wstrb=0: no array change; a response is still returned.
- RESP:
  - Hold resp_valid, resp_rdata and resp_err stable until resp_ready=1.
  - At the edge with resp_ready=1: resp_valid goes to 0, resp_rdata and resp_err go to 0, state goes to IDLE.
  - resp_ready is ignored in IDLE and WAIT.
- Throughput: one request per WAIT_CYCLES+2 cycles at best. There is no overlap; the next accept happens at the earliest one edge after the response handshake.
- Ordering: a store is committed before its response is issued, so a load issued after a store response sees the new data.
- req_valid may drop while req_ready=0; the responder does not rely on it staying high.
- Reset mid-operation:
  - Asserting rst in WAIT abandons the request; a pending store is not written.
  - Asserting rst in RESP drops the response.
  - A store already committed remains in the array.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- With the macro defined:
  - The access is flagged when addr[1:0] is not 0 (misaligned) or addr >= 4*DEPTH_WORDS (out of range).
  - A flagged access writes nothing to the array.
  - Its response has resp_rdata=0 and resp_err=1.
  - Timing is identical to a normal access.
- Without the macro:
  - resp_err is held at 0.
  - addr[1:0] is ignored and upper address bits are truncated, so addresses wrap modulo 4*DEPTH_WORDS bytes.

Decomposition:
- Package rv_mem_pkg holds:
  - the responder state enum (IDLE, WAIT, RESP);
  - the word width constant 32;
  - the strobe width constant 4;
  - the wait-counter width constant 4.
- One sub-module, dmem_array:
  - synchronous byte-lane-writable word array, DEPTH_WORDS x 32;
  - inputs: we, wstrb, index, wdata;
  - combinational read at the index.
- The FSM, counter and handshake logic stay in dmem_responder.

Test Plan:
- Reset state: hold rst=0 with req_valid=1 -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, and no accept occurs.
- Store then load, WAIT_CYCLES=2:
  - store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF accepted at edge k -> resp_valid rises at edge k+2 with resp_rdata=0;
  - a later load of 0x10 -> resp_rdata=0xDEADBEEF.
- Byte strobes: word 0x10 = 0xDEADBEEF, then store wdata 0x11223344 with wstrb 0x5 -> a load of 0x10 returns 0xDE22BE44.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable, req_ready=0 throughout, and a new req_valid is not accepted until one edge after the handshake.
- Reset mid-operation: store to 0x20 accepted, then rst=0 during WAIT -> back in IDLE after release, and a load of 0x20 returns the prior value.
- DMEM_ERR_CHECK_EN:
  - load 0x13 -> resp_err=1, resp_rdata=0;
  - store to 4*DEPTH_WORDS -> resp_err=1 and no array change;
  - without the macro, a load of 4*DEPTH_WORDS returns word 0.
